// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, size and fault codes.
// Includes the request-time legality check used when a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACCESS  = 2'b01,
    ST_RELEASE = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FLT_SIZE     = 2'b11;

  // Illegal size outranks misalignment.
  function automatic logic [1:0] req_fault(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [1:0] f;
    f = FLT_NONE;
    if (size == SZ_ILL)
      f = FLT_SIZE;
    else if (size == SZ_HALF && lo[0])
      f = FLT_MISALIGN;
    else if (size == SZ_WORD && lo != 2'b00)
      f = FLT_MISALIGN;
    return f;
  endfunction

endpackage

// File: rtl/load_extender.sv
// Sign/zero extension of RAM read data for byte, halfword and word loads.
// Ports: mem_rdata, size, sign_ext in; result out (DATA_W wide).
module load_extender
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    unique case (size)
      SZ_BYTE: begin
        result = {{(DATA_W-8){sign_ext & mem_rdata[7]}},
                  mem_rdata[7:0]};
      end
      SZ_HALF: begin
        result = {{(DATA_W-16){sign_ext & mem_rdata[15]}},
                  mem_rdata[15:0]};
      end
      default: begin
        result[31:0] = mem_rdata[31:0];
        // Only wider-than-32 paths have bits to fill.
        for (int i = 32; i < DATA_W; i++)
          result[i] = sign_ext & mem_rdata[31];
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store engine driving the RAM MOV/MOC handshake.
// Ports: req/wr/size/sign_ext/addr/wdata in; busy/done/fault/rdata out; mem_* bus.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_mov,
  output logic              mem_rw,
  output logic [1:0]        mem_dl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_moc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [1:0]        flt_q;
  logic [1:0]        req_flt;
  logic              tmo;
  logic [DATA_W-1:0] ext;

  assign req_flt = req_fault(size, addr[1:0]);
  assign tmo     = (cnt == CNT_LAST);

  load_extender #(.DATA_W(DATA_W)) u_ext (
    .mem_rdata (mem_rdata),
    .size      (size_q),
    .sign_ext  (sext_q),
    .result    (ext)
  );

  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (req)
          state_nx = (req_flt != FLT_NONE) ? ST_DONE : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (mem_moc)  state_nx = ST_RELEASE;
        else if (tmo) state_nx = ST_DONE;
      end
      ST_RELEASE: begin
        if (!mem_moc) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    fault_code = FLT_NONE;
    mem_mov    = 1'b0;
    mem_rw     = 1'b0;
    unique case (state)
      ST_IDLE: ;
      ST_ACCESS: begin
        busy    = 1'b1;
        mem_mov = 1'b1;
        mem_rw  = ~wr_q;
      end
      ST_RELEASE: busy = 1'b1;
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        fault      = (flt_q != FLT_NONE);
        fault_code = flt_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      sext_q    <= 1'b0;
      flt_q     <= FLT_NONE;
      cnt       <= '0;
      rdata     <= '0;
    end else begin
      if (state == ST_IDLE && req) begin
        mem_addr  <= addr;
        mem_wdata <= wdata;
        wr_q      <= wr;
        size_q    <= size;
        sext_q    <= sign_ext;
        flt_q     <= req_flt;
        cnt       <= '0;
      end
      if (state == ST_ACCESS) begin
        if (mem_moc) begin
          if (!wr_q) rdata <= ext;
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (tmo) flt_q <= FLT_TIMEOUT;
        end
      end
    end
  end

  assign mem_dl = size_q;

endmodule
